// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StPressed,
    StRelease
  } kp_state_e;

  // Classification of one complete four-column scan.
  typedef enum logic [1:0] {
    ScanNone,
    ScanSingle,
    ScanMulti
  } scan_kind_e;

  // Scan result: kind plus matrix position (row*4 + col) of the single key.
  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] idx;
  } scan_result_t;

  // Column drive pattern after reset: column 0 active.
  localparam logic [3:0] ColDefault = 4'b1110;

  // Hex code per matrix position, index = row*4 + col.
  // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  localparam logic [15:0][3:0] KeyMap = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Count pressed intersections; report the position when exactly one is set.
  function automatic scan_result_t classify_scan(logic [15:0] hits);
    scan_result_t res;
    int unsigned  n;
    res.kind = ScanNone;
    res.idx  = '0;
    n        = 0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        n++;
        res.idx = 4'(i);
      end
    end
    if (n == 1) begin
      res.kind = ScanSingle;
    end else if (n > 1) begin
      res.kind = ScanMulti;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins and key-event outputs. master = scanner, slave = keypad/consumer side.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_dwell_timer.sv
// Column dwell timer: rotates the active-low column drive every DWELL cycles and
// flags the last cycle of each dwell (row sample point) and of each full scan.
// DWELL must be at least 4 so synchronized rows settle before the sample.
module keypad_dwell_timer
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_o,
  output logic [1:0] col_idx_o,
  output logic       sample_o,
  output logic       scan_end_o
);

  localparam int unsigned    CntW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      col_q, col_d;

  // Next-state: count through the dwell, step column on the sample cycle.
  always_comb begin
    sample_o   = (cnt_q == CntLast);
    scan_end_o = sample_o && (idx_q == 2'd3);
    cnt_d      = sample_o ? '0 : cnt_q + CntW'(1);
    idx_d      = sample_o ? idx_q + 2'd1 : idx_q;
    col_d      = sample_o ? {col_q[2:0], col_q[3]} : col_q;
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      col_q <= ColDefault;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      col_q <= col_d;
    end
  end

  assign col_o     = col_q;
  assign col_idx_o = idx_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and single-key acceptance.
// Optional macro KEYPAD_REPEAT_EN adds REPEAT_SCANS auto-repeat while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter int unsigned DWELL_HZ       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_SCANS   = 500
`endif
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master kp
);

  localparam int unsigned     DWELL    = CLK_FREQ / DWELL_HZ;
  localparam int unsigned     DbW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DbW-1:0]  DbOne    = DbW'(1);
  localparam logic [DbW-1:0]  DbTarget = DbW'(DEBOUNCE_SCANS);
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned     RepW      = $clog2(REPEAT_SCANS + 1);
  localparam logic [RepW-1:0] RepOne    = RepW'(1);
  localparam logic [RepW-1:0] RepTarget = RepW'(REPEAT_SCANS);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  logic [3:0]     col;
  logic [1:0]     col_idx;
  logic           sample, scan_end;
  logic [3:0]     row_s1_q, row_s2_q;
  logic [15:0]    hits_q, hits_d, hits_now;
  kp_state_e      state_q, state_d;
  logic [DbW-1:0] db_q, db_d;
  logic [3:0]     cand_q, cand_d;
  logic [3:0]     held_idx_q, held_idx_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;
  scan_result_t   scan;
  logic           held_seen, accept;

  keypad_dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk       (clk),
    .reset     (reset),
    .col_o     (col),
    .col_idx_o (col_idx),
    .sample_o  (sample),
    .scan_end_o(scan_end)
  );

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
    end
  end

  // Merge the current column's rows into the accumulated scan matrix.
  always_comb begin
    hits_now = hits_q;
    for (int r = 0; r < 4; r++) begin
      hits_now[r*4 + int'(col_idx)] = ~row_s2_q[r];
    end
    hits_d = sample ? hits_now : hits_q;
  end

  // Debounce FSM, evaluated once per full scan.
  always_comb begin
    scan        = classify_scan(hits_now);
    held_seen   = hits_now[held_idx_q];
    accept      = 1'b0;
    state_d     = state_q;
    db_d        = db_q;
    cand_d      = cand_q;
    held_idx_d  = held_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (scan.kind == ScanSingle) begin
            cand_d = scan.idx;
            if (DbOne == DbTarget) begin
              accept = 1'b1;
            end else begin
              state_d = StConfirm;
              db_d    = DbOne;
            end
          end
        end
        StConfirm: begin
          if (scan.kind == ScanSingle && scan.idx == cand_q) begin
            if (db_q + DbOne == DbTarget) begin
              accept = 1'b1;
            end else begin
              db_d = db_q + DbOne;
            end
          end else begin
            state_d = StIdle;
            db_d    = '0;
          end
        end
        StPressed: begin
          // Other keys are ignored: only the held position matters here.
          if (!held_seen) begin
            if (DbOne == DbTarget) begin
              state_d = StIdle;
              db_d    = '0;
            end else begin
              state_d = StRelease;
              db_d    = DbOne;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_q + RepOne == RepTarget) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_q + RepOne;
          end
`endif
        end
        StRelease: begin
          if (held_seen) begin
            state_d = StPressed;
            db_d    = '0;
          end else if (db_q + DbOne == DbTarget) begin
            state_d = StIdle;
            db_d    = '0;
          end else begin
            db_d = db_q + DbOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (accept) begin
      state_d     = StPressed;
      db_d        = '0;
      held_idx_d  = scan.idx;
      key_code_d  = KeyMap[scan.idx];
      key_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = '0;
`endif
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q      <= '0;
      state_q     <= StIdle;
      db_q        <= '0;
      cand_q      <= '0;
      held_idx_q  <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      hits_q      <= hits_d;
      state_q     <= state_d;
      db_q        <= db_d;
      cand_q      <= cand_d;
      held_idx_q  <= held_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign kp.col       = col;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter DWELL_HZ, default 1000, column-step rate in Hz; dwell length DWELL = CLK_FREQ/DWELL_HZ cycles, at least 4.
REQ-003 Parameter DEBOUNCE_SCANS, default 4, number of consecutive identical full scans needed to accept a press or a release.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 row  input  4  keypad row lines, active-low, externally pulled up, asynchronous.
REQ-007 col  output  4  keypad column drive, active-low, one-hot-zero.
REQ-008 key_code  output  4  hex code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when a key press is accepted.
REQ-010 key_held  output  1  high while the accepted key is considered pressed.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer before any use.
REQ-012 col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing once every DWELL cycles.
REQ-013 The synchronized rows SHALL be sampled only on the last cycle of each dwell; the remaining cycles are settling time.
REQ-014 After the column-3 sample, the scan result SHALL be classified as NONE (no low row), SINGLE(code) (exactly one low row/column intersection), or MULTI (two or more); MULTI SHALL be treated as NONE.
REQ-015 Keymap, rows 0-3 by cols 0-3: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
REQ-016 FSM states and transitions:
- IDLE -> CONFIRM on SINGLE.
- CONFIRM counts consecutive SINGLE results carrying the same code.
- CONFIRM -> IDLE on NONE or on a different code.
- CONFIRM -> PRESSED when the count reaches DEBOUNCE_SCANS.
- PRESSED -> RELEASE on a scan that does not contain the held code.
- RELEASE -> PRESSED if the held code reappears.
- RELEASE -> IDLE after DEBOUNCE_SCANS consecutive scans without the held code.
REQ-017 On entry to PRESSED from CONFIRM, key_code SHALL update and key_valid SHALL pulse high for exactly one cycle, on the cycle after the qualifying sample.
REQ-018 key_held SHALL be 1 in PRESSED and RELEASE and 0 otherwise.
REQ-019 A different key pressed while in PRESSED or RELEASE SHALL be ignored: no pulse and no key_code change.
REQ-020 key_code SHALL hold its value in IDLE and CONFIRM.
REQ-021 The dwell counter SHALL be clog2(DWELL) bits wide and wrap to 0 without skipping or repeating a column.

Reset
REQ-022 On reset, the outputs SHALL be: col=1110, key_code=0, key_valid=0, key_held=0.
REQ-023 On reset, the state SHALL be IDLE, the dwell counter 0, the debounce counters 0, and the synchronizer flops 1111.
REQ-024 Reset asserted mid-press SHALL discard the press; a key still held after reset SHALL be re-qualified as a new press.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN:
- When defined, parameter REPEAT_SCANS (default 500) SHALL be added.
- In PRESSED, key_valid SHALL re-pulse with an unchanged key_code every REPEAT_SCANS full scans.
- The repeat count SHALL be cleared on entry to PRESSED and held during RELEASE.
REQ-026 Without KEYPAD_REPEAT_EN, key_valid SHALL pulse exactly once per accepted press.

Structure
REQ-027 The shared package keypad_pkg SHALL hold:
- the FSM state enum (IDLE, CONFIRM, PRESSED, RELEASE);
- the scan-result type;
- the 16-entry keymap constant;
- the default column pattern 1110.
REQ-028 A sub-module keypad_dwell_timer SHALL generate the column index and the last-cycle sample strobe; the FSM and debounce logic SHALL stay in keypad_scanner.

Verification
Bench parameters: CLK_FREQ=1000, DWELL_HZ=250 (DWELL=4, scan=16 cycles), DEBOUNCE_SCANS=4; the keypad model pulls row r low while col c is low and key (r,c) is pressed.
REQ-029 Press key (1,2) and hold for 10 scans -> exactly one key_valid pulse with key_code=6, issued 4 scans after the first scan that contains the key; key_held=1.
REQ-030 Release key (1,2) -> key_held falls after 4 clean scans; no further key_valid.
REQ-031 Press key (3,0) for 2 scans, release for 1 scan, then press for 4 scans -> no pulse after the 2-scan bounce, then one pulse with key_code=0.
REQ-032 Press keys (0,0) and (0,1) together -> no pulse while both are held; release (0,1) -> one pulse with key_code=1.
REQ-033 While key A is held in PRESSED, press key 5 as well -> key_code stays A and no pulse occurs; assert reset mid-hold -> all outputs take reset values and col=1110, then one new pulse 4 scans after reset deasserts.
REQ-034 With KEYPAD_REPEAT_EN and REPEAT_SCANS=8, hold key 9 for 30 scans -> pulses at acceptance and then every 8 scans, all with key_code=9.
